// File: rtl/cus19_pkg.sv
// Shared types and helpers for the Custom-19 crypto DMA and its cipher unit.
// Holds the DMA state encoding, the default key and single-bit rotate helpers.
package cus19_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int CUS19_DATA_W = 8;
    localparam logic [CUS19_DATA_W-1:0] CUS19_KEY = 8'hA5;

    function automatic logic [CUS19_DATA_W-1:0] rotl1(
        input logic [CUS19_DATA_W-1:0] x
    );
        return {x[CUS19_DATA_W-2:0], x[CUS19_DATA_W-1]};
    endfunction

    function automatic logic [CUS19_DATA_W-1:0] rotr1(
        input logic [CUS19_DATA_W-1:0] x
    );
        return {x[0], x[CUS19_DATA_W-1:1]};
    endfunction

endpackage

// File: rtl/cus19_crypt_rounds.sv
// Combinational multi-round XOR/rotate cipher, shared with the execute stage.
// Ports: word (input data), enc (1=encrypt, 0=decrypt), result (output data).
module cus19_crypt_rounds
    import cus19_pkg::*;
#(
    parameter int                DATA_W = CUS19_DATA_W,
    parameter int                ROUNDS = 2,
    parameter logic [DATA_W-1:0] KEY    = CUS19_KEY
) (
    input  logic [DATA_W-1:0] word,
    input  logic              enc,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] t;

    // Round key r is the base key rotated left by r mod DATA_W:
    // the upper half of the shifted doubled key is exactly that rotation.
    function automatic logic [DATA_W-1:0] round_key(input int r);
        logic [2*DATA_W-1:0] dbl;
        dbl = {KEY, KEY} << (r % DATA_W);
        return dbl[2*DATA_W-1:DATA_W];
    endfunction

    // Decrypt walks the rounds backwards, undoing rotate then XOR.
    always_comb begin
        x = word;
        t = '0;
        if (enc) begin
            for (int r = 0; r < ROUNDS; r++) begin
                t = x ^ round_key(r);
                x = {t[DATA_W-2:0], t[DATA_W-1]};
            end
        end else begin
            for (int r = ROUNDS - 1; r >= 0; r--) begin
                t = {x[0], x[DATA_W-1:1]};
                x = t ^ round_key(r);
            end
        end
    end

    assign result = x;

endmodule

// File: rtl/cus19_crypto_dma.sv
// Block-crypto DMA: streams len words src->cipher->dst over a data-memory port pair.
// Ports: start/mode/abort/src/dst/len command, dm_rd_*/dm_wr_* memory, busy/done/err/words_done status.
module cus19_crypto_dma
    import cus19_pkg::*;
#(
    parameter int                ADDR_W = 11,
    parameter int                DATA_W = 8,
    parameter int                LEN_W  = 8,
    parameter int                ROUNDS = 2,
    parameter logic [DATA_W-1:0] KEY    = CUS19_KEY
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              mode_enc_dec_in,
    input  logic              abort_in,
    input  logic [ADDR_W-1:0] src_addr_in,
    input  logic [ADDR_W-1:0] dst_addr_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic              dm_rd_req_out,
    output logic [ADDR_W-1:0] dm_rd_addr_out,
    input  logic [DATA_W-1:0] dm_rd_data_in,
    output logic              dm_wr_req_out,
    output logic [ADDR_W-1:0] dm_wr_addr_out,
    output logic [DATA_W-1:0] dm_wr_data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic [LEN_W-1:0]  words_done_out
);

    state_t state_q;
    state_t state_d;

    logic              mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [DATA_W-1:0] cap_q;
    logic [LEN_W-1:0]  words_q;
    logic              err_q;

    logic [LEN_W-1:0]  idx_nxt;
    logic [DATA_W-1:0] crypt_out;
    logic              busy;
    logic              accept;

    assign idx_nxt = idx_q + 1'b1;
    assign busy    = (state_q == ST_RD) || (state_q == ST_CAP) || (state_q == ST_WR);
    // Abort wins over a simultaneous start even from IDLE.
    assign accept  = (state_q == ST_IDLE) && start_in && !abort_in;

    cus19_crypt_rounds #(
        .DATA_W (DATA_W),
        .ROUNDS (ROUNDS),
        .KEY    (KEY)
    ) u_rounds (
        .word   (dm_rd_data_in),
        .enc    (mode_q),
        .result (crypt_out)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (len_in == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD:   state_d = abort_in ? ST_IDLE : ST_CAP;
            ST_CAP:  state_d = abort_in ? ST_IDLE : ST_WR;
            ST_WR: begin
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else if (idx_nxt == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_out       = busy;
        done_out       = (state_q == ST_DONE);
        err_out        = err_q;
        words_done_out = words_q;
        dm_rd_req_out  = 1'b0;
        dm_rd_addr_out = '0;
        dm_wr_req_out  = 1'b0;
        dm_wr_addr_out = '0;
        dm_wr_data_out = '0;
        if (state_q == ST_RD) begin
            dm_rd_req_out  = 1'b1;
            dm_rd_addr_out = src_q + ADDR_W'(idx_q);
        end
        if (state_q == ST_WR) begin
            // An abort arriving in the write cycle cancels that write.
            dm_wr_req_out  = !abort_in;
            dm_wr_addr_out = dst_q + ADDR_W'(idx_q);
            dm_wr_data_out = cap_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cap_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= busy && (start_in || abort_in);
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mode_q  <= mode_enc_dec_in;
                        src_q   <= src_addr_in;
                        dst_q   <= dst_addr_in;
                        len_q   <= len_in;
                        idx_q   <= '0;
                        words_q <= '0;
                    end
                end
                ST_CAP: begin
                    if (!abort_in) begin
                        cap_q <= crypt_out;
                    end
                end
                ST_WR: begin
                    if (!abort_in) begin
                        idx_q   <= idx_nxt;
                        words_q <= idx_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cus19_crypto_dma.sv
// Self-checking bench for cus19_crypto_dma with a behavioural memory and cipher model.
// Table vectors for the cipher, hand sequences for corner cases, random transfers.
module tb_cus19_crypto_dma;

    localparam int KEYV   = 165;
    localparam int NROUND = 2;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic        mode_enc_dec_in;
    logic        abort_in;
    logic [10:0] src_addr_in;
    logic [10:0] dst_addr_in;
    logic [7:0]  len_in;
    logic        dm_rd_req_out;
    logic [10:0] dm_rd_addr_out;
    logic [7:0]  dm_rd_data_in;
    logic        dm_wr_req_out;
    logic [10:0] dm_wr_addr_out;
    logic [7:0]  dm_wr_data_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;
    logic [7:0]  words_done_out;

    cus19_crypto_dma dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .mode_enc_dec_in (mode_enc_dec_in),
        .abort_in        (abort_in),
        .src_addr_in     (src_addr_in),
        .dst_addr_in     (dst_addr_in),
        .len_in          (len_in),
        .dm_rd_req_out   (dm_rd_req_out),
        .dm_rd_addr_out  (dm_rd_addr_out),
        .dm_rd_data_in   (dm_rd_data_in),
        .dm_wr_req_out   (dm_wr_req_out),
        .dm_wr_addr_out  (dm_wr_addr_out),
        .dm_wr_data_out  (dm_wr_data_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .err_out         (err_out),
        .words_done_out  (words_done_out)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem     [2048];
    logic [7:0]  ref_mem [2048];
    logic        bd_we;
    logic [10:0] bd_addr;
    logic [7:0]  bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (dm_wr_req_out) mem[dm_wr_addr_out] <= dm_wr_data_out;
        if (dm_rd_req_out) dm_rd_data_in <= mem[dm_rd_addr_out];
    end

    wire [42:0] outs = {dm_rd_req_out, dm_rd_addr_out, dm_wr_req_out,
                        dm_wr_addr_out, dm_wr_data_out, busy_out,
                        done_out, err_out, words_done_out};

    int vectors = 0;
    int errs    = 0;
    int lat;
    int nrd;
    int nwr;
    bit both;
    logic [10:0] rd_log [8];

    typedef struct {
        logic       enc;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int rkey(input int r);
        return ((KEYV << (r % 8)) | (KEYV >> (8 - (r % 8)))) & 255;
    endfunction

    function automatic logic [7:0] m_enc(input logic [7:0] v);
        int x;
        x = int'(v);
        for (int r = 0; r < NROUND; r++) begin
            x = x ^ rkey(r);
            x = ((x << 1) | (x >> 7)) & 255;
        end
        return 8'(x);
    endfunction

    function automatic logic [7:0] m_dec(input logic [7:0] v);
        int x;
        x = int'(v);
        for (int r = NROUND - 1; r >= 0; r--) begin
            x = ((x >> 1) | (x << 7)) & 255;
            x = x ^ rkey(r);
        end
        return 8'(x);
    endfunction

    // Transfers are defined as an in-order word-by-word copy through the cipher.
    task automatic ref_xfer(input logic enc, input logic [10:0] s,
                            input logic [10:0] d, input int l);
        for (int i = 0; i < l; i++) begin
            logic [10:0] sa;
            logic [10:0] da;
            sa = 11'(int'(s) + i);
            da = 11'(int'(d) + i);
            ref_mem[da] = enc ? m_enc(ref_mem[sa]) : m_dec(ref_mem[sa]);
        end
    endtask

    task automatic cmp_mem(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < 2048; a++) begin
            if (mem[a] !== ref_mem[a]) begin
                if (bad == 0)
                    $display("FAIL %s: mem[%0h] got %0h, expected %0h",
                             name, a, mem[a], ref_mem[a]);
                bad++;
            end
        end
        check({name, "_bad_words"}, 64'(bad), 64'd0);
    endtask

    task automatic poke(input logic [10:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic run_xfer(input logic enc, input logic [10:0] s,
                            input logic [10:0] d, input logic [7:0] l);
        @(posedge clk); #1;
        start_in = 1'b1; mode_enc_dec_in = enc;
        src_addr_in = s; dst_addr_in = d; len_in = l;
        @(posedge clk); #1;
        start_in = 1'b0;
        lat = -1; nrd = 0; nwr = 0; both = 1'b0;
        for (int n = 1; n <= 3 * int'(l) + 10; n++) begin
            @(negedge clk);
            if (dm_rd_req_out) begin
                if (nrd < 8) rd_log[nrd] = dm_rd_addr_out;
                nrd++;
            end
            if (dm_wr_req_out) nwr++;
            if (dm_rd_req_out && dm_wr_req_out) both = 1'b1;
            if (done_out) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int seen;
        int n;
        logic       e;
        logic [10:0] s;
        logic [10:0] d;
        logic [7:0]  l;

        tbl[0] = '{1'b1, 8'h3C, 8'hF0};
        tbl[1] = '{1'b1, 8'h00, 8'h00};
        tbl[2] = '{1'b1, 8'hFF, 8'hFF};
        tbl[3] = '{1'b1, 8'h5A, 8'h69};
        tbl[4] = '{1'b1, 8'h01, 8'h04};
        tbl[5] = '{1'b0, 8'hF0, 8'h3C};
        tbl[6] = '{1'b0, 8'h69, 8'h5A};
        tbl[7] = '{1'b0, 8'h04, 8'h01};

        rst_in = 1'b1; start_in = 1'b0; mode_enc_dec_in = 1'b0;
        abort_in = 1'b0; src_addr_in = '0; dst_addr_in = '0; len_in = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(outs), 64'd0);

        @(negedge clk);
        rst_in = 1'b0;
        for (int a = 0; a < 2048; a++) begin
            bd_we = 1'b1; bd_addr = 11'(a); bd_data = 8'($urandom);
            ref_mem[a] = bd_data;
            @(negedge clk);
        end
        bd_we = 1'b0;
        @(negedge clk);
        check("idle_outputs", 64'(outs), 64'd0);

        for (int i = 0; i < 8; i++) begin
            poke(11'(16 + i), tbl[i].din);
            run_xfer(tbl[i].enc, 11'(16 + i), 11'(32 + i), 8'd1);
            ref_xfer(tbl[i].enc, 11'(16 + i), 11'(32 + i), 1);
            @(negedge clk);
            check($sformatf("tbl%0d_data", i), 64'(mem[32 + i]), 64'(tbl[i].dout));
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd4);
        end
        cmp_mem("table");

        poke(11'h080, 8'h3C); poke(11'h081, 8'h00);
        poke(11'h082, 8'hFF); poke(11'h083, 8'h5A);
        run_xfer(1'b1, 11'h080, 11'h100, 8'd4);
        ref_xfer(1'b1, 11'h080, 11'h100, 4);
        @(negedge clk);
        check("rt_enc_word0", 64'(mem[11'h100]), 64'hF0);
        check("rt_enc_word1", 64'(mem[11'h101]), 64'h00);
        run_xfer(1'b0, 11'h100, 11'h200, 8'd4);
        ref_xfer(1'b0, 11'h100, 11'h200, 4);
        @(negedge clk);
        check("rt_dec_word0", 64'(mem[11'h200]), 64'h3C);
        check("rt_dec_word1", 64'(mem[11'h201]), 64'h00);
        check("rt_dec_word2", 64'(mem[11'h202]), 64'hFF);
        check("rt_dec_word3", 64'(mem[11'h203]), 64'h5A);
        check("rt_latency", 64'(lat), 64'd13);

        run_xfer(1'b1, 11'h7FE, 11'h400, 8'd4);
        ref_xfer(1'b1, 11'h7FE, 11'h400, 4);
        check("wrap_rd0", 64'(rd_log[0]), 64'h7FE);
        check("wrap_rd1", 64'(rd_log[1]), 64'h7FF);
        check("wrap_rd2", 64'(rd_log[2]), 64'h000);
        check("wrap_rd3", 64'(rd_log[3]), 64'h001);
        check("wrap_words_done", 64'(words_done_out), 64'd4);
        @(negedge clk);
        cmp_mem("wrap");

        run_xfer(1'b1, 11'h123, 11'h456, 8'd0);
        check("len0_latency", 64'(lat), 64'd1);
        check("len0_reads", 64'(nrd), 64'd0);
        check("len0_writes", 64'(nwr), 64'd0);
        check("len0_words_done", 64'(words_done_out), 64'd0);

        @(posedge clk); #1;
        start_in = 1'b1; mode_enc_dec_in = 1'b1;
        src_addr_in = 11'h500; dst_addr_in = 11'h600; len_in = 8'd5;
        @(posedge clk); #1;
        start_in = 1'b0;
        for (int k = 1; k <= 8; k++) @(negedge clk);
        @(posedge clk); #1;
        abort_in = 1'b1;
        @(negedge clk);
        check("abort_wr_suppressed", 64'(dm_wr_req_out), 64'd0);
        check("abort_busy_in_wr", 64'(busy_out), 64'd1);
        @(posedge clk); #1;
        abort_in = 1'b0;
        @(negedge clk);
        check("abort_err", 64'(err_out), 64'd1);
        check("abort_idle", 64'(busy_out), 64'd0);
        check("abort_words_done", 64'(words_done_out), 64'd2);
        ref_xfer(1'b1, 11'h500, 11'h600, 2);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_out || dm_rd_req_out || dm_wr_req_out) seen = 1;
        end
        check("abort_quiet_after", 64'(seen), 64'd0);
        cmp_mem("abort");

        @(posedge clk); #1;
        start_in = 1'b1; mode_enc_dec_in = 1'b1;
        src_addr_in = 11'h520; dst_addr_in = 11'h620; len_in = 8'd3;
        @(posedge clk); #1;
        start_in = 1'b0;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        start_in = 1'b1; mode_enc_dec_in = 1'b0;
        src_addr_in = 11'h700; dst_addr_in = 11'h000; len_in = 8'd9;
        @(negedge clk);
        @(posedge clk); #1;
        start_in = 1'b0;
        @(negedge clk);
        check("busy_start_err", 64'(err_out), 64'd1);
        n = 4; lat = -1;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (done_out) begin
                lat = n;
                break;
            end
        end
        check("busy_start_latency", 64'(lat), 64'd10);
        check("busy_start_words", 64'(words_done_out), 64'd3);
        ref_xfer(1'b1, 11'h520, 11'h620, 3);
        @(negedge clk);
        check("busy_start_err_gone", 64'(err_out), 64'd0);
        cmp_mem("busy_start");

        @(posedge clk); #1;
        start_in = 1'b1; mode_enc_dec_in = 1'b1;
        src_addr_in = 11'h540; dst_addr_in = 11'h640; len_in = 8'd3;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_in = 1'b1;
        @(negedge clk);
        check("rst_mid_rd_req", 64'(dm_rd_req_out), 64'd1);
        @(posedge clk); #1;
        rst_in = 1'b0;
        @(negedge clk);
        check("rst_outputs_zero", 64'(outs), 64'd0);
        ref_xfer(1'b1, 11'h540, 11'h640, 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (outs != 43'd0) seen = 1;
        end
        check("rst_stays_idle", 64'(seen), 64'd0);
        cmp_mem("rst");

        for (int it = 0; it < 24; it++) begin
            e = 1'($urandom);
            s = 11'($urandom);
            d = (it % 5 == 0) ? s : 11'($urandom);
            l = 8'($urandom_range(0, 12));
            run_xfer(e, s, d, l);
            ref_xfer(e, s, d, int'(l));
            check($sformatf("rnd%0d_latency", it), 64'(lat), 64'(3 * int'(l) + 1));
            check($sformatf("rnd%0d_words", it), 64'(words_done_out), 64'(l));
            check($sformatf("rnd%0d_excl", it), 64'(both), 64'd0);
            @(negedge clk);
            check($sformatf("rnd%0d_done_pulse", it), 64'(done_out), 64'd0);
            cmp_mem($sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
